// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_scan_ctrl
//  Purpose  : Multiplexed 7-segment scan driver for NDIG hex digits. Features:
//             - per-digit decimal point
//             - leading-zero blanking
//             - PWM brightness
//             - double-buffered digit data, committed at frame boundaries
//  Options  : SEG7_BLINK_EN adds the i_blink port and a frame counter that
//             blinks the selected digits.
//  Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl #(
  parameter int NDIG    = 8,
`ifdef SEG7_BLINK_EN
  parameter int BLINK_W = 6,
`endif
  parameter int DIV_W   = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic [4*NDIG-1:0] i_data,
  input  logic [NDIG-1:0]   i_dp,
  input  logic              i_lz,
  input  logic [3:0]        i_bright,
`ifdef SEG7_BLINK_EN
  input  logic [NDIG-1:0]   i_blink,
`endif
  output logic [7:0]        o_seg,
  output logic [NDIG-1:0]   o_sel,
  output logic              o_frame
);

  localparam int               IDX_W    = $clog2(NDIG);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIG - 1);

  // Scan timing state
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  // Pending (CPU-written) and active (displayed) digit buffers
  logic [4*NDIG-1:0] pend_data_q, pend_data_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
  logic              pend_lz_q, pend_lz_d;
  logic [4*NDIG-1:0] act_data_q, act_data_d;
  logic [NDIG-1:0]   act_dp_q, act_dp_d;
  logic              act_lz_q, act_lz_d;

  // Registered pin drivers
  logic [7:0]        seg_q, seg_d;
  logic [NDIG-1:0]   sel_q, sel_d;
  logic              frame_q, frame_d;

  logic              tick;
  logic              commit;

`ifdef SEG7_BLINK_EN
  logic [BLINK_W-1:0] blink_q, blink_d;
`endif

  // Segment pattern for a..g (active low); decimal point handled separately
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Next-state for scan counters and the double buffer; a write coinciding
  // with the commit bypasses the pending buffer so it is not lost for a frame.
  always_comb begin
    tick        = &cnt_q;
    commit      = tick && (idx_q == LAST_IDX);
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    if (tick) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
    pend_data_d = pend_data_q;
    pend_dp_d   = pend_dp_q;
    pend_lz_d   = pend_lz_q;
    if (cs) begin
      pend_data_d = i_data;
      pend_dp_d   = i_dp;
      pend_lz_d   = i_lz;
    end
    act_data_d  = act_data_q;
    act_dp_d    = act_dp_q;
    act_lz_d    = act_lz_q;
    if (commit) begin
      act_data_d = pend_data_d;
      act_dp_d   = pend_dp_d;
      act_lz_d   = pend_lz_d;
    end
    frame_d     = commit;
`ifdef SEG7_BLINK_EN
    blink_d     = commit ? blink_q + 1'b1 : blink_q;
`endif
  end

  // Pin pattern for the current slot: decode, blanking and PWM gating
  logic [3:0] nib;
  logic       dp_cur;
  logic       zero_above;
  logic       lz_blank;
  logic       lit;
  logic       blink_blank;

  always_comb begin
    nib        = act_data_q[{idx_q, 2'b00} +: 4];
    dp_cur     = act_dp_q[idx_q];
    zero_above = 1'b1;
    lz_blank   = 1'b0;
    // Walk from the most significant digit down; a digit blanks only when it
    // and every digit to its left are zero. Digit 0 is excluded.
    for (int k = NDIG - 1; k >= 1; k--) begin
      zero_above = zero_above && (act_data_q[4*k +: 4] == 4'h0);
      if ((idx_q == IDX_W'(k)) && zero_above && act_lz_q) begin
        lz_blank = 1'b1;
      end
    end
    lit        = (cnt_q[DIV_W-1 -: 4] <= i_bright);
`ifdef SEG7_BLINK_EN
    blink_blank = blink_q[BLINK_W-1] && i_blink[idx_q];
`else
    blink_blank = 1'b0;
`endif
    seg_d = 8'hFF;
    sel_d = '1;
    if (lit) begin
      for (int k = 0; k < NDIG; k++) begin
        if (idx_q == IDX_W'(k)) begin
          sel_d[k] = 1'b0;
        end
      end
      if (blink_blank) begin
        seg_d = 8'hFF;
      end else if (lz_blank) begin
        seg_d = {~dp_cur, 7'h7F};
      end else begin
        seg_d = {~dp_cur, hex7(nib)};
      end
    end
  end

  // State and output registers, cleared immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dp_q   <= '0;
      pend_lz_q   <= 1'b0;
      act_data_q  <= '0;
      act_dp_q    <= '0;
      act_lz_q    <= 1'b0;
      seg_q       <= 8'hFF;
      sel_q       <= '1;
      frame_q     <= 1'b0;
`ifdef SEG7_BLINK_EN
      blink_q     <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dp_q   <= pend_dp_d;
      pend_lz_q   <= pend_lz_d;
      act_data_q  <= act_data_d;
      act_dp_q    <= act_dp_d;
      act_lz_q    <= act_lz_d;
      seg_q       <= seg_d;
      sel_q       <= sel_d;
      frame_q     <= frame_d;
`ifdef SEG7_BLINK_EN
      blink_q     <= blink_d;
`endif
    end
  end

  assign o_seg   = seg_q;
  assign o_sel   = sel_q;
  assign o_frame = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg7_scan_ctrl
//  Purpose  : Self-checking bench for seg7_scan_ctrl (NDIG=4, DIV_W=4)
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;
  localparam int NDIG  = 4;
  localparam int DIV_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic [15:0] i_data;
  logic [3:0]  i_dp;
  logic        i_lz;
  logic [3:0]  i_bright;
  logic [3:0]  i_blink;
  logic [7:0]  o_seg;
  logic [3:0]  o_sel;
  logic        o_frame;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NDIG    (NDIG),
`ifdef SEG7_BLINK_EN
    .BLINK_W (2),
`endif
    .DIV_W   (DIV_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cs       (cs),
    .i_data   (i_data),
    .i_dp     (i_dp),
    .i_lz     (i_lz),
    .i_bright (i_bright),
`ifdef SEG7_BLINK_EN
    .i_blink  (i_blink),
`endif
    .o_seg    (o_seg),
    .o_sel    (o_sel),
    .o_frame  (o_frame)
  );

  // Full active-low patterns with the dp bit off
  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: elapsed cycles since reset plus the two buffers
  int          n;
  int          frames;
  logic [15:0] m_pend, m_act;
  logic [3:0]  m_pdp, m_adp;
  logic        m_plz, m_alz;
  logic [7:0]  e_seg;
  logic [3:0]  e_sel;
  logic        e_frame;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    n = 0; frames = 0;
    m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0; m_plz = 1'b0; m_alz = 1'b0;
  endtask

  // One clock: predict the pins from the pre-edge state, advance, compare
  task automatic step();
    int          c, ix;
    logic [15:0] sh;
    logic        lit, lzb, blk, commit, dp;
    c      = n % 16;
    ix     = (n / 16) % 4;
    sh     = m_act >> (4 * ix);
    dp     = m_adp[ix];
    lit    = (c <= int'(i_bright));
    lzb    = m_alz && (ix >= 1) && (sh == 16'h0);
`ifdef SEG7_BLINK_EN
    blk    = (((frames / 2) % 2) == 1) && i_blink[ix];
`else
    blk    = 1'b0;
`endif
    commit = (n % 64) == 63;
    if (!lit) begin
      e_seg = 8'hFF; e_sel = 4'hF;
    end else begin
      e_sel = ~(4'b0001 << ix);
      if (blk)      e_seg = 8'hFF;
      else if (lzb) e_seg = {~dp, 7'h7F};
      else          e_seg = {~dp, hex_tbl[sh[3:0]][6:0]};
    end
    e_frame = commit;
    if (cs) begin
      m_pend = i_data; m_pdp = i_dp; m_plz = i_lz;
    end
    @(posedge clk);
    if (commit) begin
      m_act = m_pend; m_adp = m_pdp; m_alz = m_plz; frames++;
    end
    n++;
    #1;
    check("seg", o_seg, e_seg);
    check("sel", o_sel, e_sel);
    check("frame", o_frame, e_frame);
  endtask

  task automatic write(input logic [15:0] d, input logic [3:0] dp, input logic lz);
    cs = 1'b1; i_data = d; i_dp = dp; i_lz = lz;
    step();
    cs = 1'b0;
  endtask

  // Step until o_frame is seen; reports cycles taken
  task automatic wait_frame(output int cyc);
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      cyc++;
      if (o_frame) return;
    end
    check("frame_timeout", 32'd0, 32'd1);
  endtask

  task automatic mid_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_seg", o_seg, 8'hFF);
    check("rst_sel", o_sel, 4'hF);
    check("rst_frame", o_frame, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int cyc, low_cnt;
    reset = 1'b1; cs = 1'b0; i_data = '0; i_dp = '0; i_lz = 1'b0;
    i_bright = 4'hF; i_blink = 4'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("por_seg", o_seg, 8'hFF);
    check("por_sel", o_sel, 4'hF);
    check("por_frame", o_frame, 1'b0);
    reset = 1'b0;
    step();
    check("first_sel", o_sel, 4'hE);
    check("first_seg", o_seg, 8'hC0);

    // Scan order and frame period with 1234
    write(16'h1234, 4'h0, 1'b0);
    wait_frame(cyc);
    step(); check("d0_sel", o_sel, 4'hE); check("d0_seg", o_seg, 8'h99);
    repeat (16) step(); check("d1_sel", o_sel, 4'hD); check("d1_seg", o_seg, 8'hB0);
    repeat (16) step(); check("d2_sel", o_sel, 4'hB); check("d2_seg", o_seg, 8'hA4);
    repeat (16) step(); check("d3_sel", o_sel, 4'h7); check("d3_seg", o_seg, 8'hF9);
    wait_frame(cyc);
    wait_frame(cyc);
    check("frame_period", cyc, 64);

    // Mid-frame write stays hidden until the frame boundary
    repeat (20) step();
    write(16'hABCD, 4'h0, 1'b0);
    repeat (5) step();
    check("buf_old_seg", (o_seg == 8'hFF) || (o_seg != 8'hA1), 1'b1);
    wait_frame(cyc);
    step(); check("buf_new_seg", o_seg, 8'hA1);

    // Write landing exactly on the commit cycle, with leading-zero blanking
    for (int k = 0; k < 70 && (n % 64) != 63; k++) step();
    write(16'h0050, 4'b1000, 1'b1);
    check("commit_frame", o_frame, 1'b1);
    step(); check("lz_d0", o_seg, 8'hC0);
    repeat (16) step(); check("lz_d1", o_seg, 8'h92);
    repeat (16) step(); check("lz_d2", o_seg, 8'hFF);
    repeat (16) step(); check("lz_d3", o_seg, 8'h7F);

    // Brightness duty
    i_bright = 4'h3; low_cnt = 0;
    wait_frame(cyc);
    for (int k = 0; k < 64; k++) begin step(); if (o_sel != 4'hF) low_cnt++; end
    check("bright3_low", low_cnt, 16);
    i_bright = 4'h0; low_cnt = 0;
    for (int k = 0; k < 64; k++) begin step(); if (o_sel != 4'hF) low_cnt++; end
    check("bright0_low", low_cnt, 4);

    // Randomised traffic with a reset in the middle
    i_bright = 4'hF;
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) mid_reset();
      cs = ($urandom_range(0, 7) == 0);
      if (cs) begin
        i_data = 16'($urandom) >> (4 * $urandom_range(0, 3));
        i_dp   = 4'($urandom);
        i_lz   = 1'($urandom);
      end
      if ($urandom_range(0, 31) == 0) i_bright = 4'($urandom);
      step();
    end
    cs = 1'b0;

`ifdef SEG7_BLINK_EN
    i_bright = 4'hF; i_blink = 4'b0001;
    write(16'h1234, 4'h0, 1'b0);
    for (int f = 0; f < 8; f++) wait_frame(cyc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
